// File: rtl/meas_seq_ctrl.sv
// meas_seq_ctrl: campaign sequencer for the spi_master readout path.
// Each run pulses the measured device's reset, requests a start, waits for the
// measurement-done flag, requests a fetch and waits for both fetch acks. It
// then idles for a gap and repeats, or finishes after NUM_RUNS runs.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   go_i                   campaign request, acts on a 0->1 edge
//   abort_i                synchronous level abort, highest priority
//   done_i                 measurement done (asynchronous, 2-flop synced)
//   fetch0_i, fetch1_i     fetch acknowledges (asynchronous, 2-flop synced)
//   dut_reset_o            reset to the measured device, active-high
//   sw_start_o, sw_fetch_o start / fetch requests to spi_master
//   busy_o                 campaign in progress
//   run_cnt_o              completed runs in the current/last campaign
//   campaign_done_o        one-cycle pulse on successful completion
//   timeout_o              sticky watchdog error
//
// Build option: define MEAS_SEQ_WATCHDOG_EN to add a per-wait-state watchdog
// (TIMEOUT_CYC cycles in START or FETCH sends the FSM to ERROR). Without it
// the wait states wait forever and timeout_o is tied low.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a go_i edge, all outputs low
// RST    | dut_reset_o high for RST_CYC cycles
// START  | sw_start_o high until synced done
// FETCH  | sw_fetch_o high until both synced fetch acks are high together
// GAP    | all requests low for GAP_CYC cycles, then next run
// FINISH | campaign_done_o pulse, back to IDLE
// ERROR  | watchdog fired: timeout_o and dut_reset_o held high

module meas_seq_ctrl #(
    parameter int unsigned NUM_RUNS    = 4,
    parameter int unsigned RST_CYC     = 8,
    parameter int unsigned GAP_CYC     = 16,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       go_i,
    input  logic       abort_i,
    input  logic       done_i,
    input  logic       fetch0_i,
    input  logic       fetch1_i,
    output logic       dut_reset_o,
    output logic       sw_start_o,
    output logic       sw_fetch_o,
    output logic       busy_o,
    output logic [7:0] run_cnt_o,
    output logic       campaign_done_o,
    output logic       timeout_o
);

    localparam int unsigned PH_W = 16;
    localparam logic [PH_W-1:0] RST_LOAD = PH_W'(RST_CYC - 1);
    localparam logic [PH_W-1:0] GAP_LOAD = PH_W'(GAP_CYC - 1);
    localparam logic [7:0]      RUNS_MAX = 8'(NUM_RUNS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_START,
        S_FETCH,
        S_GAP,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [7:0]      cnt_d;
    logic            go_q, go_edge_q;
    logic [1:0]      done_sync_q, f0_sync_q, f1_sync_q;
    logic            done_s, acks_s;
    logic            wd_expired;

    assign done_s = done_sync_q[1];
    assign acks_s = f0_sync_q[1] & f1_sync_q[1];

    // go_q resets high so a go_i already high at reset release is not an edge.
    // Edges seen while busy are dropped so they cannot fire after FINISH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            go_q        <= 1'b1;
            go_edge_q   <= 1'b0;
            done_sync_q <= 2'b00;
            f0_sync_q   <= 2'b00;
            f1_sync_q   <= 2'b00;
        end else begin
            go_q        <= go_i;
            go_edge_q   <= go_i & ~go_q & ~busy_o;
            done_sync_q <= {done_sync_q[0], done_i};
            f0_sync_q   <= {f0_sync_q[0], fetch0_i};
            f1_sync_q   <= {f1_sync_q[0], fetch1_i};
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = (ph_q != '0) ? ph_q - 1'b1 : ph_q;
        cnt_d   = run_cnt_o;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (go_edge_q) begin
                    state_d = S_RST;
                    ph_d    = RST_LOAD;
                    cnt_d   = 8'd0;
                end
            end
            S_RST: begin
                if (ph_q == '0) state_d = S_START;
            end
            S_START: begin
                if (done_s)          state_d = S_START == S_START ? S_FETCH : S_START;
                else if (wd_expired) state_d = S_ERROR;
            end
            S_FETCH: begin
                if (acks_s) begin
                    if (run_cnt_o < RUNS_MAX) cnt_d = run_cnt_o + 8'd1;
                    if (cnt_d == RUNS_MAX) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_GAP;
                        ph_d    = GAP_LOAD;
                    end
                end else if (wd_expired) begin
                    state_d = S_ERROR;
                end
            end
            S_GAP: begin
                if (ph_q == '0) begin
                    state_d = S_RST;
                    ph_d    = RST_LOAD;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort_i) begin
            state_d = S_IDLE;
            cnt_d   = run_cnt_o;
        end
    end

    // Outputs are decoded from the next state and registered with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_IDLE;
            ph_q            <= '0;
            run_cnt_o       <= 8'd0;
            dut_reset_o     <= 1'b0;
            sw_start_o      <= 1'b0;
            sw_fetch_o      <= 1'b0;
            busy_o          <= 1'b0;
            campaign_done_o <= 1'b0;
        end else begin
            state_q         <= state_d;
            ph_q            <= ph_d;
            run_cnt_o       <= cnt_d;
            dut_reset_o     <= (state_d == S_RST) || (state_d == S_ERROR);
            sw_start_o      <= (state_d == S_START);
            sw_fetch_o      <= (state_d == S_FETCH);
            busy_o          <= (state_d != S_IDLE) && (state_d != S_ERROR);
            campaign_done_o <= (state_d == S_FINISH);
        end
    end

`ifdef MEAS_SEQ_WATCHDOG_EN
    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_q;
    logic            wd_load, timeout_d;

    assign wd_expired = (wd_q == '0);

    always_comb begin
        wd_load   = (state_d != state_q) &&
                    ((state_d == S_START) || (state_d == S_FETCH));
        timeout_d = timeout_o;
        if ((state_d == S_ERROR) && (state_q != S_ERROR))
            timeout_d = 1'b1;
        else if ((state_d == S_RST) && ((state_q == S_IDLE) || (state_q == S_ERROR)))
            timeout_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q      <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (wd_load)          wd_q <= WD_LOAD;
            else if (!wd_expired) wd_q <= wd_q - 1'b1;
            timeout_o <= timeout_d;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_meas_seq_ctrl.sv
module tb_meas_seq_ctrl;

    localparam int NUM_RUNS    = 2;
    localparam int RST_CYC     = 8;
    localparam int GAP_CYC     = 16;
    localparam int TIMEOUT_CYC = 16;

    logic       clk_i = 1'b0;
    logic       rst_ni, go_i, abort_i, done_i, fetch0_i, fetch1_i;
    logic       dut_reset_o, sw_start_o, sw_fetch_o, busy_o, campaign_done_o, timeout_o;
    logic [7:0] run_cnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    meas_seq_ctrl #(
        .NUM_RUNS   (NUM_RUNS),
        .RST_CYC    (RST_CYC),
        .GAP_CYC    (GAP_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .go_i           (go_i),
        .abort_i        (abort_i),
        .done_i         (done_i),
        .fetch0_i       (fetch0_i),
        .fetch1_i       (fetch1_i),
        .dut_reset_o    (dut_reset_o),
        .sw_start_o     (sw_start_o),
        .sw_fetch_o     (sw_fetch_o),
        .busy_o         (busy_o),
        .run_cnt_o      (run_cnt_o),
        .campaign_done_o(campaign_done_o),
        .timeout_o      (timeout_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; go_i = 1'b0; abort_i = 1'b0;
        done_i = 1'b0; fetch0_i = 1'b0; fetch1_i = 1'b0;
        tick(); tick();
        checks++; if ({dut_reset_o, sw_start_o, sw_fetch_o, busy_o, campaign_done_o, timeout_o} !== 6'b0)
            begin errors++; $display("FAIL reset_flags: got %b want 000000", {dut_reset_o, sw_start_o, sw_fetch_o, busy_o, campaign_done_o, timeout_o}); end
        checks++; if (run_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", run_cnt_o); end
        rst_ni = 1'b1;
        repeat (4) tick();
        checks++; if (busy_o !== 1'b0 || dut_reset_o !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %b dut_reset %b want 0 0", busy_o, dut_reset_o); end
    endtask

    // Leaves the bench at the first sample of the RST state.
    task automatic start_campaign();
        go_i = 1'b0; tick();
        go_i = 1'b1; tick();
        checks++; if (dut_reset_o !== 1'b0) begin errors++; $display("FAIL go_latency_early: dut_reset %b want 0", dut_reset_o); end
        tick();
        checks++; if (dut_reset_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL go_latency: dut_reset %b busy %b want 1 1", dut_reset_o, busy_o); end
        checks++; if (run_cnt_o !== 8'd0) begin errors++; $display("FAIL go_cnt_clear: got %0d want 0", run_cnt_o); end
    endtask

    // Expected timing from the sequencing rules: RST_CYC reset samples, start
    // held until 3 edges after done, fetch held until 3 edges after the later
    // ack, GAP_CYC gap samples, then one done pulse after the last run.
    // A negative delay argument picks a random one.
    task automatic run_campaign(input int d_done, input int d_f0, input int d_f1,
                                input bit go_in_gap, input int abort_at);
        int n, d, a, b, mx;
        bit bad;
        for (int r = 0; r < NUM_RUNS; r++) begin
            n = 0;
            while (dut_reset_o === 1'b1 && n < 100) begin
                if (sw_start_o !== 1'b0) bad = 1'b1;
                n++; tick();
            end
            checks++; if (n !== RST_CYC) begin errors++; $display("FAIL rst_len run %0d: got %0d want %0d", r, n, RST_CYC); end
            checks++; if (sw_start_o !== 1'b1) begin errors++; $display("FAIL start_after_rst: got %b want 1", sw_start_o); end

            d = (d_done < 0) ? int'($urandom_range(0, 20)) : d_done;
            repeat (d) tick();
            done_i = 1'b1;
            n = 0;
            while (sw_start_o === 1'b1 && n < 50) begin n++; tick(); end
            checks++; if (n !== 3) begin errors++; $display("FAIL start_exit_lat: got %0d want 3", n); end
            checks++; if (sw_fetch_o !== 1'b1 || dut_reset_o !== 1'b0) begin errors++; $display("FAIL fetch_entry: fetch %b dut_reset %b want 1 0", sw_fetch_o, dut_reset_o); end

            if (r == abort_at) begin
                tick(); tick();
                abort_i = 1'b1; tick(); abort_i = 1'b0;
                checks++; if ({sw_fetch_o, sw_start_o, dut_reset_o, busy_o} !== 4'b0) begin errors++; $display("FAIL abort_outputs: got %b want 0000", {sw_fetch_o, sw_start_o, dut_reset_o, busy_o}); end
                checks++; if (run_cnt_o !== 8'(r)) begin errors++; $display("FAIL abort_cnt_held: got %0d want %0d", run_cnt_o, r); end
                done_i = 1'b0;
                return;
            end

            a  = (d_f0 < 0) ? int'($urandom_range(0, 15)) : d_f0;
            b  = (d_f1 < 0) ? int'($urandom_range(0, 15)) : d_f1;
            mx = (a > b) ? a : b;
            for (int k = 0; k <= mx; k++) begin
                if (k == a) fetch0_i = 1'b1;
                if (k == b) fetch1_i = 1'b1;
                if (k < mx) tick();
            end
            n = 0;
            while (sw_fetch_o === 1'b1 && n < 50) begin
                if (n == 0) begin
                    checks++; if (run_cnt_o !== 8'(r)) begin errors++; $display("FAIL cnt_early: got %0d want %0d", run_cnt_o, r); end
                end
                n++; tick();
            end
            checks++; if (n !== 3) begin errors++; $display("FAIL fetch_exit_lat (a=%0d b=%0d): got %0d want 3", a, b, n); end
            checks++; if (run_cnt_o !== 8'(r + 1)) begin errors++; $display("FAIL cnt_inc: got %0d want %0d", run_cnt_o, r + 1); end
            done_i = 1'b0; fetch0_i = 1'b0; fetch1_i = 1'b0;

            if (r + 1 < NUM_RUNS) begin
                n = 0; bad = 1'b0;
                while (dut_reset_o !== 1'b1 && n < 100) begin
                    if (go_in_gap && n == 2) go_i = 1'b0;
                    if (go_in_gap && n == 5) go_i = 1'b1;
                    if (busy_o !== 1'b1 || sw_start_o !== 1'b0 || sw_fetch_o !== 1'b0 || campaign_done_o !== 1'b0) bad = 1'b1;
                    n++; tick();
                end
                checks++; if (n !== GAP_CYC) begin errors++; $display("FAIL gap_len: got %0d want %0d", n, GAP_CYC); end
                checks++; if (bad !== 1'b0) begin errors++; $display("FAIL gap_outputs: got bad=%b want 0", bad); end
            end else begin
                checks++; if (campaign_done_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL finish: done %b busy %b want 1 1", campaign_done_o, busy_o); end
                tick();
                checks++; if (campaign_done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL finish_pulse: done %b busy %b want 0 0", campaign_done_o, busy_o); end
                checks++; if (run_cnt_o !== 8'(NUM_RUNS)) begin errors++; $display("FAIL final_cnt: got %0d want %0d", run_cnt_o, NUM_RUNS); end
                repeat (4) tick();
                checks++; if (busy_o !== 1'b0 || dut_reset_o !== 1'b0) begin errors++; $display("FAIL stay_idle: busy %b dut_reset %b want 0 0", busy_o, dut_reset_o); end
            end
        end
    endtask

    task automatic test_nominal();
        start_campaign();
        run_campaign(20, 10, 10, 1'b0, -1);
    endtask

    task automatic test_staggered();
        start_campaign();
        run_campaign(-1, 5, 12, 1'b0, -1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            start_campaign();
            run_campaign(-1, -1, -1, 1'b0, -1);
        end
    endtask

    task automatic test_ignored_edges();
        start_campaign();
        run_campaign(-1, -1, -1, 1'b1, -1);
    endtask

    task automatic test_abort();
        start_campaign();
        run_campaign(-1, -1, -1, 1'b0, 1);
        repeat (3) tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_stays_idle: busy %b want 0", busy_o); end
        go_i = 1'b0; tick();
        go_i = 1'b1; abort_i = 1'b1;
        tick(); tick();
        abort_i = 1'b0;
        repeat (3) tick();
        checks++; if (busy_o !== 1'b0 || dut_reset_o !== 1'b0) begin errors++; $display("FAIL abort_beats_go: busy %b dut_reset %b want 0 0", busy_o, dut_reset_o); end
        checks++; if (run_cnt_o !== 8'd1) begin errors++; $display("FAIL abort_go_cnt: got %0d want 1", run_cnt_o); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        start_campaign();
        n = 0;
        while (sw_start_o !== 1'b1 && n < 50) begin n++; tick(); end
        checks++; if (sw_start_o !== 1'b1) begin errors++; $display("FAIL reach_start: got %b want 1", sw_start_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if ({dut_reset_o, sw_start_o, sw_fetch_o, busy_o, campaign_done_o, timeout_o} !== 6'b0 || run_cnt_o !== 8'd0)
            begin errors++; $display("FAIL async_reset: flags %b cnt %0d want 000000 0", {dut_reset_o, sw_start_o, sw_fetch_o, busy_o, campaign_done_o, timeout_o}, run_cnt_o); end
        tick(); tick();
        rst_ni = 1'b1;
        repeat (6) tick();
        checks++; if (busy_o !== 1'b0 || dut_reset_o !== 1'b0) begin errors++; $display("FAIL held_go_no_start: busy %b dut_reset %b want 0 0", busy_o, dut_reset_o); end
        start_campaign();
        abort_i = 1'b1; tick(); abort_i = 1'b0; tick();
    endtask

    task automatic test_watchdog();
        int n;
        start_campaign();
        n = 0;
        while (dut_reset_o === 1'b1 && n < 50) begin n++; tick(); end
        n = 0;
        while (sw_start_o === 1'b1 && n < 1000) begin n++; tick(); end
`ifdef MEAS_SEQ_WATCHDOG_EN
        checks++; if (n !== TIMEOUT_CYC) begin errors++; $display("FAIL wd_len: got %0d want %0d", n, TIMEOUT_CYC); end
        repeat (5) tick();
        checks++; if ({timeout_o, dut_reset_o, busy_o, sw_start_o, sw_fetch_o} !== 5'b11000)
            begin errors++; $display("FAIL wd_error: got %b want 11000", {timeout_o, dut_reset_o, busy_o, sw_start_o, sw_fetch_o}); end
        go_i = 1'b0; tick();
        go_i = 1'b1; tick(); tick();
        checks++; if ({timeout_o, dut_reset_o, busy_o} !== 3'b011) begin errors++; $display("FAIL wd_restart: got %b want 011", {timeout_o, dut_reset_o, busy_o}); end
`else
        checks++; if (n !== 1000) begin errors++; $display("FAIL no_wd_wait: got %0d want 1000", n); end
        checks++; if ({sw_start_o, busy_o, timeout_o} !== 3'b110) begin errors++; $display("FAIL no_wd_state: got %b want 110", {sw_start_o, busy_o, timeout_o}); end
`endif
        abort_i = 1'b1; tick(); abort_i = 1'b0; tick();
        checks++; if (busy_o !== 1'b0 || dut_reset_o !== 1'b0) begin errors++; $display("FAIL wd_abort: busy %b dut_reset %b want 0 0", busy_o, dut_reset_o); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_staggered();
        test_random();
        test_ignored_edges();
        test_abort();
        test_reset_mid_run();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/meas_seq_ctrl.md
# meas_seq_ctrl

Campaign sequencer that drives the SPI readout master through repeated measurement runs without software stepping each one. Per run: pulse the DUT reset, raise start, wait for the measurement-done flag, raise fetch, wait for both fetch-acknowledge flags. It then either gaps and repeats or finishes after `NUM_RUNS` runs. It sits between the board-level go/abort switches and the `spi_master` start/fetch request inputs, replacing the manual switch inputs.

## Interface

**Parameters**
- `NUM_RUNS`, 4: runs per campaign, 1..255.
- `RST_CYC`, 8: cycles `dut_reset_o` is held per run, ≥1.
- `GAP_CYC`, 16: idle cycles between runs, ≥1.
- `TIMEOUT_CYC`, 1024: watchdog limit per wait state, ≥4.

**Ports**
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `go_i`  in  1  campaign request; rising edge acts.
- `abort_i`  in  1  synchronous abort, level.
- `done_i`  in  1  measurement done from DUT; asynchronous, 2-flop synchronized internally.
- `fetch0_i`  in  1  fetch ack 0; 2-flop synchronized.
- `fetch1_i`  in  1  fetch ack 1; 2-flop synchronized.
- `dut_reset_o`  out  1  DUT reset, active-high.
- `sw_start_o`  out  1  start request to `spi_master`.
- `sw_fetch_o`  out  1  fetch request to `spi_master`.
- `busy_o`  out  1  campaign in progress.
- `run_cnt_o`  out  8  completed runs in current/last campaign.
- `campaign_done_o`  out  1  one-cycle pulse on successful completion.
- `timeout_o`  out  1  sticky watchdog error.

## Operation

**States:** IDLE, RST, START, FETCH, GAP, FINISH, ERROR. All outputs are registered Moore outputs.

**Transitions**
- **IDLE:**
  - `go_i` rising edge (registered edge detect) → RST.
  - `run_cnt_o` cleared on that transition.
  - `timeout_o` cleared on that transition.
- **RST:**
  - `dut_reset_o`=1 for exactly `RST_CYC` cycles → START.
- **START:**
  - `sw_start_o`=1.
  - Synchronized done=1 → FETCH.
- **FETCH:**
  - `sw_fetch_o`=1.
  - Synchronized fetch0 AND fetch1 both 1 in the same cycle → `run_cnt_o`+1.
  - Then: if new count == `NUM_RUNS` → FINISH, else → GAP.
- **GAP:**
  - All request outputs 0 for `GAP_CYC` cycles → RST.
- **FINISH:**
  - `campaign_done_o`=1 for one cycle → IDLE.
- **ERROR:**
  - `timeout_o`=1.
  - `dut_reset_o`=1 held.
  - Start/fetch requests 0.
  - Exit only via `go_i` rising edge (→ RST, timeout cleared) or `abort_i` (→ IDLE).

**`busy_o`:** 1 in RST, START, FETCH, GAP, FINISH; 0 in IDLE and ERROR.

**Abort**
- `abort_i`=1 in any state → IDLE next cycle.
- All request outputs drop the same edge.
- `run_cnt_o` is held.
- Abort has priority over `go_i` edges and every other transition.

**Boundary rules**
- `go_i` edges while `busy_o`=1 are ignored.
- A `go_i` held high through reset release does not start a campaign. The edge detector resets to 1, so a fresh 0→1 is required.
- Done or fetch acks arriving in other states are ignored.
- Stale-high done at START entry is accepted (level-sensitive). The `spi_master` clears done on its own reset, which `dut_reset_o` drives.
- `run_cnt_o` saturates at `NUM_RUNS`; no wrap.
- `rst_ni` low mid-run: immediate return to IDLE, all outputs 0.

## Timing

- **Reset values:** all outputs 0; state IDLE; synchronizers 0; edge register 1.
- **`go_i` to `dut_reset_o`:** `go_i` rises at edge N → edge detect N+1 → `dut_reset_o`=1 from N+2.
- **RST to START:** `sw_start_o` rises the cycle after the last `dut_reset_o`=1 cycle. `dut_reset_o` and `sw_start_o` are never both high.
- **Input latency:** done/fetch inputs reach the FSM 2 cycles after arriving at the pins. `sw_start_o` falls and `sw_fetch_o` rises 3 edges after `done_i` rises.
- **Minimum run length:** `RST_CYC` + 3 + 3 + 1 cycles. Gap not included.

## Configuration

- **`MEAS_SEQ_WATCHDOG_EN` defined:**
  - A cycle counter restarts on entry to START and FETCH.
  - If a wait state is still pending after `TIMEOUT_CYC` cycles in that state → ERROR.
  - Completion and timeout in the same cycle: completion wins.
- **Not defined:**
  - No counter is instantiated.
  - START and FETCH wait indefinitely.
  - `timeout_o` is tied to 0.
  - ERROR is unreachable.

## Test plan

- **Nominal campaign:** `NUM_RUNS`=2, model acks done 20 cycles after start and fetch0/1 10 cycles after fetch → two `dut_reset_o` pulses of 8 cycles, `run_cnt_o`=2, one `campaign_done_o` pulse, `busy_o` low afterwards.
- **Staggered acks:** fetch0 at +5, fetch1 at +12 cycles → FETCH exits only after fetch1 syncs; count increments by exactly 1.
- **Watchdog:** with `MEAS_SEQ_WATCHDOG_EN`, `TIMEOUT_CYC`=16, done never asserted → ERROR after 16 START cycles, `timeout_o`=1, `dut_reset_o`=1 held. A new `go_i` edge clears `timeout_o` and restarts. Without the macro → still in START after 1000 cycles.
- **Abort mid-FETCH:** `abort_i` pulses → `sw_fetch_o`=0 next edge, state IDLE, `run_cnt_o` unchanged. `abort_i` and a `go_i` edge in the same IDLE cycle → stays IDLE.
- **Reset mid-run:** `rst_ni` low during START → all outputs 0 asynchronously. `go_i` held high across reset release → no campaign until `go_i` toggles low then high.
- **Ignored edges:** `go_i` re-pulsed during GAP → no restart, `run_cnt_o` continues to `NUM_RUNS`.
